breathing_led_multi: RTL and testbench
======================================

Name: breathing_led_multi

Overview:
Multi-channel, parametrised successor to the single-channel breathing LED. A shared prescaler and PWM frame counter drive CHANNELS independent level/direction generators. Each channel has a run-time mode (off, on, breathe, blink). Channels can start phase-spread so that several LEDs breathe in a staggered wave. The block sits at board level between the system clock and the LED pins.

Parameters:
CHANNELS, 4, number of LED outputs (1..16)
CNT_TICK_MAX, 99, prescaler terminal count; one PWM tick every CNT_TICK_MAX+1 clk cycles (2 us at 50 MHz)
LEVELS, 1000, PWM resolution and ramp length; one frame = LEVELS ticks; one full breath = 2*LEVELS frames
PHASE_SPREAD, 1, 1: channel i resets to level (i*LEVELS)/CHANNELS; 0: all channels reset to level 0
ACTIVE_LOW, 0, 1: every led bit is inverted at the output register

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]; 0=OFF, 1=ON, 2=BREATHE, 3=BLINK; sampled every cycle
sync  input  1  single-cycle pulse; restarts all counters to their reset phase without touching led polarity
frame_end  output  1  pulse, high for one cycle at the last tick of each PWM frame
led  output  CHANNELS  registered LED drive

Behaviour:
- Reset, and sync when rst is low:
  - prescaler=0, pwm_cnt=0.
  - All lvl[i] take their PHASE_SPREAD reset value; all dir[i]=up.
  - frame_end=0; led = all 0 (all 1 if ACTIVE_LOW).
  - rst has priority over sync.
- Prescaler:
  - Counts 0..CNT_TICK_MAX and wraps.
  - tick is asserted combinationally when prescaler==CNT_TICK_MAX.
- PWM counter:
  - pwm_cnt (width $clog2(LEVELS)) increments on tick and wraps from LEVELS-1 to 0.
  - frame_end is registered: it goes high the cycle after tick && pwm_cnt==LEVELS-1.
- Level update, per channel, on the same condition as frame_end:
  - dir up: if lvl==LEVELS-1 then dir<=down and lvl holds; else lvl+1.
  - dir down: if lvl==0 then dir<=up and lvl holds; else lvl-1.
  - Endpoints therefore last 2 frames, and the period is exactly 2*LEVELS frames.
- Level counters run in every mode, so a mode change never resets phase.
- Output decode, registered with 1-cycle latency from pwm_cnt/lvl/mode:
  - OFF: 0.
  - ON: 1.
  - BREATHE: (pwm_cnt < lvl). lvl=0 is fully dark; lvl=LEVELS-1 is on LEVELS-1 of LEVELS ticks.
  - BLINK: dir==up. Square wave with period 2*LEVELS frames.
  - XOR ACTIVE_LOW applied last.
- A mode change takes effect on led exactly one clk after mode changes.
- Simultaneous sync and frame-end condition: sync wins, with no level step.
- Reset mid-operation: all state returns to reset values on the next edge, and no partial frame_end is emitted.
- Width rules: all compares are unsigned. LEVELS must be >= 2 and CNT_TICK_MAX >= 0. CNT_TICK_MAX=0 means tick every cycle.

Decomposition:
- Package breathing_led_pkg holds:
  - the mode enum: MODE_OFF, MODE_ON, MODE_BREATHE, MODE_BLINK as a 2-bit typedef;
  - the dir typedef (DIR_UP/DIR_DOWN).
- One natural sub-module, breathing_led_channel, generated CHANNELS times. It contains lvl/dir state, the reset/phase value as a parameter, and the output decode. Inputs: frame_step, sync, pwm_cnt, mode.
- The top level holds the prescaler, pwm_cnt, frame_end and the generate loop.

Test Plan:
Bench parameters unless noted: CHANNELS=2, CNT_TICK_MAX=1, LEVELS=4, PHASE_SPREAD=1, ACTIVE_LOW=0; one breath = 64 cycles.
1. Hold rst 3 cycles, then release -> led=00 and frame_end=0 during reset; first frame_end at cycle 8 after release, then every 8 cycles.
2. mode=BREATHE on both channels, run 64 cycles -> ch0 lvl sequence per frame 0,1,2,3,3,2,1,0; ch1 sequence 2,3,3,2,1,0,0,1. ch0 led high count per frame (2 cycles per tick) = 0,2,4,6,6,4,2,0.
3. mode ch0=ON, ch1=OFF, then switch ch0 to BLINK mid-frame -> led[0]=1 and led[1]=0 until 1 cycle after the switch; then led[0] follows dir, high for 32 cycles and low for 32 cycles.
4. Pulse sync at the same cycle as a frame-end condition -> no level step and no frame_end that cycle; ch1 lvl returns to 2 and pwm_cnt returns to 0.
5. Assert rst mid-breath (lvl=3, dir down) for 1 cycle -> the next cycle shows lvl0=0, lvl1=2, dir=up and led=00, then a clean restart as in scenario 1.
6. ACTIVE_LOW=1, PHASE_SPREAD=0, all channels OFF -> led=11 during and after reset; in BREATHE both channels are identical at every cycle.

Source files
------------

// File: rtl/breathing_led_pkg.sv
// -----------------------------------------------------------------------------
// breathing_led_pkg
//
// Shared types for the multi-channel breathing LED block.
//   mode_t : per-channel run-time mode, 2 bits wide, packed two bits per
//            channel on the top-level mode bus.
//   dir_t  : ramp direction of a channel's level counter.
//   phase_level : reset level of channel idx when the channels are spread
//                 evenly across one ramp.
// -----------------------------------------------------------------------------
package breathing_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Evenly spaced start levels: channel idx starts at (idx*levels)/channels.
  function automatic int phase_level(input int idx, input int channels,
                                     input int levels);
    return (idx * levels) / channels;
  endfunction

endpackage

// File: rtl/breathing_led_channel.sv
// -----------------------------------------------------------------------------
// breathing_led_channel
//
// One LED channel: a level counter that ramps up and down once per frame
// step, plus the registered output decode for the selected mode.
//
// Parameters:
//   LEVELS     : PWM resolution / ramp length (>= 2)
//   LVL_RST    : level loaded on reset and on sync (0..LEVELS-1)
//   ACTIVE_LOW : 1 inverts the led output
//
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   sync       in  restart to the reset phase (same effect as rst)
//   frame_step in  advance the level counter by one step (end of PWM frame)
//   pwm_cnt    in  shared PWM position within the current frame
//   mode       in  2-bit channel mode (see breathing_led_pkg::mode_t)
//   led        out registered LED drive
// -----------------------------------------------------------------------------
module breathing_led_channel
  import breathing_led_pkg::*;
#(
  parameter int LEVELS     = 1000,
  parameter int LVL_RST    = 0,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int LW         = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          frame_step,
  input  logic [LW-1:0] pwm_cnt,
  input  logic [1:0]    mode,
  output logic          led
);

  localparam logic [LW-1:0] LVL_MAX  = LW'(LEVELS - 1);
  localparam logic [LW-1:0] LVL_INIT = LW'(LVL_RST);

  logic [LW-1:0] lvl;
  logic [LW-1:0] lvl_next;
  dir_t          dir;
  dir_t          dir_next;
  logic          led_raw;
  logic          led_next;

  // State registers. sync restarts the channel exactly like reset, and also
  // wins over a coincident frame step.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      lvl <= LVL_INIT;
      dir <= DIR_UP;
      led <= ACTIVE_LOW;
    end else begin
      lvl <= lvl_next;
      dir <= dir_next;
      led <= led_next;
    end
  end

  // Level ramp. At each endpoint the step only flips the direction and the
  // level holds, so both endpoints last two frames and a full breath is
  // exactly 2*LEVELS frames.
  always_comb begin
    lvl_next = lvl;
    dir_next = dir;
    if (frame_step) begin
      case (dir)
        DIR_UP: begin
          if (lvl == LVL_MAX) dir_next = DIR_DOWN;
          else                lvl_next = lvl + LW'(1);
        end
        DIR_DOWN: begin
          if (lvl == '0) dir_next = DIR_UP;
          else           lvl_next = lvl - LW'(1);
        end
        default: begin
          dir_next = DIR_UP;
        end
      endcase
    end
  end

  // Output decode from the current (pre-update) state; the register above
  // gives the one-cycle latency from mode/pwm_cnt/lvl to led.
  always_comb begin
    led_raw = 1'b0;
    case (mode_t'(mode))
      MODE_OFF:     led_raw = 1'b0;
      MODE_ON:      led_raw = 1'b1;
      MODE_BREATHE: led_raw = (pwm_cnt < lvl);
      MODE_BLINK:   led_raw = (dir == DIR_UP);
      default:      led_raw = 1'b0;
    endcase
    led_next = led_raw ^ ACTIVE_LOW;
  end

endmodule

// File: rtl/breathing_led_multi.sv
// -----------------------------------------------------------------------------
// breathing_led_multi
//
// Multi-channel breathing LED driver. A shared prescaler produces a PWM tick
// every CNT_TICK_MAX+1 clocks; a shared PWM counter sweeps 0..LEVELS-1 ticks
// per frame; CHANNELS independent channels ramp their level once per frame
// and decode their LED from the selected mode.
//
// Parameters:
//   CHANNELS     : number of LED outputs (1..16)
//   CNT_TICK_MAX : prescaler terminal count (0 = tick every clock)
//   LEVELS       : PWM resolution and ramp length (>= 2)
//   PHASE_SPREAD : 1 = channels start evenly spread over the ramp, 0 = all at 0
//   ACTIVE_LOW   : 1 = every led bit inverted
//
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset (priority over sync)
//   mode      in  per-channel mode, channel i at bits [2i+1:2i]
//   sync      in  single-cycle pulse restarting every counter to its reset phase
//   frame_end out one-cycle pulse following the last tick of each frame
//   led       out registered LED drive, one bit per channel
// -----------------------------------------------------------------------------
module breathing_led_multi
  import breathing_led_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_TICK_MAX = 99,
  parameter int LEVELS       = 1000,
  parameter int PHASE_SPREAD = 1,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  sync,
  output logic                  frame_end,
  output logic [CHANNELS-1:0]   led
);

  localparam int PW = (CNT_TICK_MAX > 0) ? $clog2(CNT_TICK_MAX + 1) : 1;
  localparam int LW = $clog2(LEVELS);

  localparam logic [PW-1:0] PRE_MAX = PW'(CNT_TICK_MAX);
  localparam logic [LW-1:0] PWM_MAX = LW'(LEVELS - 1);

  logic [PW-1:0] prescaler;
  logic [LW-1:0] pwm_cnt;
  logic          tick;
  logic          frame_step;

  assign tick       = (prescaler == PRE_MAX);
  assign frame_step = tick && (pwm_cnt == PWM_MAX);

  // Prescaler: 0..CNT_TICK_MAX, wrapping.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // PWM position within the frame: advances once per tick, wraps at LEVELS-1.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      if (pwm_cnt == PWM_MAX) pwm_cnt <= '0;
      else                    pwm_cnt <= pwm_cnt + LW'(1);
    end
  end

  // frame_end trails the frame-step condition by one clock. Clearing it on
  // sync means a sync coinciding with the last tick emits no pulse.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      frame_end <= 1'b0;
    end else begin
      frame_end <= frame_step;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int RST_LVL = (PHASE_SPREAD != 0) ?
                             phase_level(i, CHANNELS, LEVELS) : 0;

    breathing_led_channel #(
      .LEVELS     (LEVELS),
      .LVL_RST    (RST_LVL),
      .ACTIVE_LOW (ACTIVE_LOW != 0),
      .LW         (LW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sync       (sync),
      .frame_step (frame_step),
      .pwm_cnt    (pwm_cnt),
      .mode       (mode[2*i+1:2*i]),
      .led        (led[i])
    );
  end

endmodule

// File: tb/tb_breathing_led_multi.sv
// -----------------------------------------------------------------------------
// tb_breathing_led_multi
//
// Directed bench for breathing_led_multi with CHANNELS=2, CNT_TICK_MAX=1,
// LEVELS=4: one tick every 2 clocks, one frame every 8 clocks, one breath
// every 64 clocks. A second instance with PHASE_SPREAD=0, ACTIVE_LOW=1 shares
// clk/rst/sync and has its own mode bus.
//
// Cycle numbering: j counts clock edges since the last edge that sampled
// rst (or sync) high; outputs are sampled 1 time unit after each edge, so the
// led value at j reflects the state during cycle j-1.
// -----------------------------------------------------------------------------
module tb_breathing_led_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [3:0] mode = 4'b0000;
  logic [3:0] mode2 = 4'b0000;
  logic       frame_end;
  logic [1:0] led;
  logic       frame_end2;
  logic [1:0] led2;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-frame high-cycle counts in BREATHE: 2 clocks per tick, lvl ticks high.
  // ch0 starts at lvl 0 (0,1,2,3,3,2,1,0), ch1 at lvl 2 (2,3,3,2,1,0,0,1).
  int exp0[8] = '{0, 2, 4, 6, 6, 4, 2, 0};
  int exp1[8] = '{4, 6, 6, 4, 2, 0, 0, 2};
  // Level per frame for a channel starting at 0 (frames 0..8).
  int lv0[9]  = '{0, 1, 2, 3, 3, 2, 1, 0, 0};

  always #5 clk = ~clk;

  breathing_led_multi #(
    .CHANNELS     (2),
    .CNT_TICK_MAX (1),
    .LEVELS       (4),
    .PHASE_SPREAD (1),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sync      (sync),
    .frame_end (frame_end),
    .led       (led)
  );

  breathing_led_multi #(
    .CHANNELS     (2),
    .CNT_TICK_MAX (1),
    .LEVELS       (4),
    .PHASE_SPREAD (0),
    .ACTIVE_LOW   (1)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode2),
    .sync      (sync),
    .frame_end (frame_end2),
    .led       (led2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for n edges, checking reset outputs on both instances.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick_n(1);
      check("rst_led", led, 32'd0);
      check("rst_fe", frame_end, 32'd0);
      check("rst_led2", led2, 32'd3);
    end
    rst = 1'b0;
  endtask

  // Run nframes frames from a fresh phase, checking frame_end every cycle
  // and per-frame high counts of both channels of the main instance.
  task automatic run_breathe(input string tag, input int nframes);
    int c0;
    int c1;
    for (int f = 0; f < nframes; f++) begin
      c0 = 0;
      c1 = 0;
      for (int s = 1; s <= 8; s++) begin
        tick_n(1);
        c0 += int'(led[0]);
        c1 += int'(led[1]);
        check($sformatf("%s_fe_f%0d_s%0d", tag, f, s), frame_end,
              (s == 8) ? 32'd1 : 32'd0);
      end
      check($sformatf("%s_ch0_hi_f%0d", tag, f), c0, exp0[f]);
      check($sformatf("%s_ch1_hi_f%0d", tag, f), c1, exp1[f]);
    end
  endtask

  initial begin
    logic       e0;
    logic [1:0] e2;
    int         f;

    // Scenarios 1+2: reset, then a full breath in BREATHE on both channels.
    mode = 4'b1010;
    do_reset(3);
    run_breathe("s2", 8);

    // Scenario 3: ch0 ON, ch1 OFF, then ch0 to BLINK during a down phase.
    mode = 4'b0001;
    do_reset(2);
    for (int j = 1; j <= 100; j++) begin
      tick_n(1);
      if (j <= 36) e0 = 1'b1;
      else         e0 = (((j - 1) / 32) % 2 == 0);
      check($sformatf("s3_led_j%0d", j), led, {31'd0, e0});
      if (j == 36) mode = 4'b0011;
    end

    // Scenario 4: sync on the cycle that would end frame 1.
    mode = 4'b1010;
    do_reset(1);
    run_breathe("s4a", 1);
    for (int j = 9; j <= 15; j++) begin
      tick_n(1);
      check($sformatf("s4_fe_j%0d", j), frame_end, 32'd0);
    end
    sync = 1'b1;
    tick_n(1);
    sync = 1'b0;
    check("s4_sync_fe", frame_end, 32'd0);
    check("s4_sync_led", led, 32'd0);
    run_breathe("s4b", 2);

    // Scenario 5: reset mid-breath (ch0 lvl 3, dir down in frame 4).
    do_reset(1);
    run_breathe("s5a", 4);
    tick_n(2);
    check("s5_pre_led", led, 32'd3);
    rst = 1'b1;
    tick_n(1);
    check("s5_rst_led", led, 32'd0);
    check("s5_rst_fe", frame_end, 32'd0);
    rst = 1'b0;
    run_breathe("s5b", 2);

    // Scenario 6: active-low, no phase spread; OFF then BREATHE.
    mode2 = 4'b0000;
    do_reset(3);
    for (int j = 1; j <= 8; j++) begin
      tick_n(1);
      check($sformatf("s6_off_j%0d", j), led2, 32'd3);
      check($sformatf("s6_fe2_j%0d", j), frame_end2, (j == 8) ? 32'd1 : 32'd0);
    end
    mode2 = 4'b1010;
    for (int j = 9; j <= 72; j++) begin
      tick_n(1);
      f = (j - 1) / 8;
      e0 = !((((j - 1) % 8) / 2) < lv0[f]);
      e2 = {e0, e0};
      check($sformatf("s6_led2_j%0d", j), led2, {30'd0, e2});
      check($sformatf("s6_fe2_j%0d", j), frame_end2,
            (j % 8 == 0) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
